// File: rtl/spi_slave_rx.sv
// rtl/spi_slave_rx.sv - SPI slave receive deserialiser with FWFT word FIFO
//
// Samples master_data_out on every rising clk edge while chip_sel is low,
// assembles MSB-first DATA_W-bit words and pushes each completed word into a
// DEPTH-entry first-word-fall-through FIFO.
//
// Ports:
//   clk             system clock, all sampling on rising edge
//   reset           synchronous active-low reset
//   chip_sel        slave select from master, active-low
//   master_data_out serial data from master
//   rd_en           pop the head word (ignored while rx_empty)
//   rx_data         FIFO head word, valid while rx_empty=0
//   rx_empty        FIFO empty
//   rx_full         FIFO full
//   rx_count        number of words held (0..DEPTH)
//   busy            high while a frame is being shifted in
//   frame_err       one-cycle pulse: frame ended on a partial word
//   overflow        sticky: a completed word was dropped on a full FIFO
module spi_slave_rx #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       chip_sel,
    input  logic                       master_data_out,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rx_data,
    output logic                       rx_empty,
    output logic                       rx_full,
    output logic [$clog2(DEPTH):0]     rx_count,
    output logic                       busy,
    output logic                       frame_err,
    output logic                       overflow
);

    localparam int CW = $clog2(DATA_W);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t              state;
    logic [CW-1:0]       bit_cnt;
    logic [DATA_W-1:0]   shift_reg;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW:0]         count;

    logic                last_bit;
    logic                push;
    logic                pop;
    logic                push_ok;
    logic                fifo_full;
    logic [DATA_W-1:0]   word_in;

    // The completing edge sees the final bit on the wire, so the word is
    // formed from the shift register plus the live input bit.
    assign last_bit  = (bit_cnt == CW'(DATA_W - 1));
    assign word_in   = {shift_reg[DATA_W-2:0], master_data_out};
    assign push      = !chip_sel && last_bit;
    assign pop       = rd_en && (count != '0);
    assign fifo_full = (count == (AW+1)'(DEPTH));
    // A same-edge pop frees the slot, so a full FIFO can still accept.
    assign push_ok   = push && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (!chip_sel) begin
                // IDLE and SHIFT sample identically; the state only tracks
                // whether a frame is open.
                state     <= SHIFT;
                shift_reg <= word_in;
                bit_cnt   <= last_bit ? '0 : bit_cnt + 1'b1;
            end else begin
                state     <= IDLE;
                bit_cnt   <= '0;
                shift_reg <= '0;
                if (state == SHIFT && bit_cnt != '0)
                    frame_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= word_in;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !push_ok)
                overflow <= 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rx_data  = mem[rd_ptr];
    assign rx_empty = (count == '0);
    assign rx_full  = fifo_full;
    assign rx_count = count;
    assign busy     = (state == SHIFT);

endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
Receive-side stage downstream of the spi master block. Samples the master's serial output while chip_sel is low and deserialises it MSB-first into DATA_W-bit words. Completed words go into a small first-word-fall-through FIFO for the local consumer. Flags frames that end on a partial word and writes that hit a full FIFO.

Parameters:
DATA_W, 8, word width in bits (2..32)
DEPTH, 4, FIFO depth in words (power of two, >=2)

Ports:
clk  input  1  system clock; all sampling on rising edge
reset  input  1  synchronous, active-low reset
chip_sel  input  1  slave select from master, active-low
master_data_out  input  1  serial data from master, sampled while chip_sel=0
rd_en  input  1  pop head word; ignored when rx_empty=1
rx_data  output  DATA_W  FIFO head word, valid when rx_empty=0
rx_empty  output  1  FIFO empty
rx_full  output  1  FIFO full
rx_count  output  log2(DEPTH)+1  words held
busy  output  1  1 while in SHIFT state
frame_err  output  1  one-cycle pulse: chip_sel rose mid-word
overflow  output  1  sticky: a completed word was dropped because FIFO full

Behaviour:
- Reset (reset=0 at rising edge): state=IDLE, bit counter=0, shift reg=0, FIFO pointers=0. rx_data=0, rx_empty=1, rx_full=0, rx_count=0, busy=0, frame_err=0, overflow=0. Reset mid-frame discards the partial word and all FIFO contents; no frame_err.
- FSM states IDLE and SHIFT.
  - IDLE to SHIFT: on an edge with chip_sel=0. That same edge samples bit 0 (the MSB).
  - SHIFT: every edge with chip_sel=0 shifts master_data_out into the LSB and increments the bit counter.
  - SHIFT to IDLE: on an edge with chip_sel=1.
- Word completion: the edge that samples bit DATA_W-1 writes {shift[DATA_W-2:0], master_data_out} into the FIFO at that same edge. The bit counter wraps to 0 and the FSM stays in SHIFT, so back-to-back words in one frame have no gap.
- Partial word: chip_sel=1 seen in SHIFT with bit counter != 0.
  - The partial word is discarded.
  - frame_err=1 for exactly the next cycle.
  - The bit counter clears.
- chip_sel=1 with bit counter=0: no error.
- busy=1 exactly while state=SHIFT.
- FIFO is first-word-fall-through:
  - rx_data shows the head combinationally from storage and is held stable while rx_empty=1.
  - rd_en with rx_empty=0 advances the head at that edge.
- Simultaneous push and pop:
  - Non-empty FIFO: both happen and rx_count is unchanged.
  - Full FIFO: both happen, no overflow, and the FIFO stays full.
  - Empty FIFO: the push happens and the pop is ignored.
- Push while full without a valid pop: the word is dropped and overflow sets. overflow stays 1 until reset. Stored words are untouched.
- Pointers wrap modulo DEPTH. rx_count is registered, ranges 0..DEPTH, and updates at the push/pop edge.
- No combinational path from master_data_out or chip_sel to any output.

Test Plan:
1. DATA_W=8, DEPTH=4. Hold chip_sel=0 for 8 cycles sending 0xA5 MSB-first, then chip_sel=1 -> after the 8th edge: rx_empty=0, rx_data=0xA5, rx_count=1, frame_err never 1. Pulse rd_en -> rx_empty=1, rx_count=0.
2. One 16-cycle frame sending 0x3C then 0xC3 -> rx_count=2 after edge 16; reads return 0x3C then 0xC3; busy=1 for 16 cycles, then 0.
3. Five bits 10110, then chip_sel=1 -> frame_err=1 for exactly one cycle, rx_empty stays 1. Next 8-bit frame 0x5A is received correctly (bit alignment restarted).
4. Send 5 words 0x01..0x05 with no reads -> rx_full=1, rx_count=4, overflow=1 after the 5th word. Reads return 0x01..0x04 (0x05 lost); overflow still 1 after draining.
5. FIFO full with 0x01..0x04; assert rd_en on the edge 0x06 completes -> overflow stays 0, rx_count=4, read order 0x02,0x03,0x04,0x06.
6. Reset=0 for one edge after 4 bits of a frame -> every output at its reset value, no frame_err. Release reset, send 0xFF -> rx_data=0xFF.
